// File: rtl/regfile_wb_if.sv
// regfile_wb_if -- W-stage commit bus and decode read ports of the Y86-64
// register file.
//
// Signals:
//   W_stat, W_icode        status / icode of the entry in the W stage
//   W_valE, W_valM         ALU result and memory read result
//   W_dstE, W_dstM         destination registers (4'hF = none)
//   d_srcA, d_srcB         decode read addresses (4'hF = none)
//   d_rvalA, d_rvalB       combinational read data
//
// Modports:
//   master -- the pipeline: drives the W entry and the read addresses
//   slave  -- the register file: consumes them and returns the read data
//
// There is no valid/ready handshake on this bus: the W entry is consumed
// unconditionally on every rising clock edge, and a bubble is signalled by
// W_icode = 1 with both destinations set to 4'hF.
interface regfile_wb_if;
  logic [3:0]  W_stat;
  logic [3:0]  W_icode;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;
  logic [3:0]  d_srcA;
  logic [3:0]  d_srcB;
  logic [63:0] d_rvalA;
  logic [63:0] d_rvalB;

  modport master (
    output W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM, d_srcA, d_srcB,
    input  d_rvalA, d_rvalB
  );

  modport slave (
    input  W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM, d_srcA, d_srcB,
    output d_rvalA, d_rvalB
  );
endinterface

// File: rtl/regfile_wb.sv
// regfile_wb -- Y86-64 register file and retirement unit.
//
// Commits the W-stage results into the 15 architectural registers, serves
// two combinational decode read ports, latches the processor status and
// counts retired instructions. A retired HLT/ADR/INS entry freezes all
// architectural state until reset.
//
// Ports:
//   clk          pipeline clock, all state updates on the rising edge
//   rst_n        synchronous active-low reset
//   wb           regfile_wb_if.slave: W entry in, read addresses in, read data out
//   cpu_stat     architectural status (1 AOK, 2 HLT, 3 ADR, 4 INS)
//   halted       high whenever the block is not in RUN
//   retired_cnt  count of retired non-NOP instructions (wraps)
//   state_dbg    current FSM state (0 RUN, 1 HALTED, 2 FAULT)
//
// Parameters:
//   CNT_W        width of retired_cnt
//
// Build option:
//   REGFILE_WB_BYPASS_EN  when defined, a register being written by an AOK
//                         entry in RUN is forwarded to the read ports in the
//                         same cycle (valM has priority over valE).
module regfile_wb #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  regfile_wb_if.slave      wb,
  output logic [3:0]       cpu_stat,
  output logic             halted,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [1:0]       state_dbg
);

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] STAT_AOK = 4'd1;
  localparam logic [3:0] STAT_HLT = 4'd2;
  localparam logic [3:0] STAT_ADR = 4'd3;
  localparam logic [3:0] STAT_INS = 4'd4;
  localparam logic [3:0] ICODE_NOP = 4'd1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  stat_nxt;
  logic        cnt_inc;
  logic        we_e, we_m;
  logic [63:0] regs [0:14];

  // Next-state, status, write enables and counter increment.
  always_comb begin
    state_nxt = state;
    stat_nxt  = cpu_stat;
    cnt_inc   = 1'b0;
    we_e      = 1'b0;
    we_m      = 1'b0;
    if (state == ST_RUN) begin
      case (wb.W_stat)
        STAT_AOK: begin
          we_e    = (wb.W_dstE != REG_NONE);
          we_m    = (wb.W_dstM != REG_NONE);
          cnt_inc = (wb.W_icode != ICODE_NOP);
        end
        STAT_HLT: begin
          state_nxt = ST_HALTED;
          stat_nxt  = STAT_HLT;
          cnt_inc   = (wb.W_icode != ICODE_NOP);
        end
        STAT_ADR, STAT_INS: begin
          state_nxt = ST_FAULT;
          stat_nxt  = wb.W_stat;
        end
        // Undefined status codes are treated as an invalid instruction.
        default: begin
          state_nxt = ST_FAULT;
          stat_nxt  = STAT_INS;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      cpu_stat    <= STAT_AOK;
      retired_cnt <= '0;
      for (int i = 0; i < 15; i++) regs[i] <= '0;
    end else begin
      state    <= state_nxt;
      cpu_stat <= stat_nxt;
      if (cnt_inc) retired_cnt <= retired_cnt + 1'b1;
      if (we_e) regs[wb.W_dstE] <= wb.W_valE;
      // Issued after the valE write so valM wins when both target the same
      // register (popq %rsp).
      if (we_m) regs[wb.W_dstM] <= wb.W_valM;
    end
  end

  assign halted    = (state != ST_RUN);
  assign state_dbg = state;

  // Read ports.
  always_comb begin
    wb.d_rvalA = '0;
    wb.d_rvalB = '0;
    if (wb.d_srcA != REG_NONE) wb.d_rvalA = regs[wb.d_srcA];
    if (wb.d_srcB != REG_NONE) wb.d_rvalB = regs[wb.d_srcB];
`ifdef REGFILE_WB_BYPASS_EN
    if (state == ST_RUN && wb.W_stat == STAT_AOK) begin
      if (wb.d_srcA != REG_NONE && wb.d_srcA == wb.W_dstM)      wb.d_rvalA = wb.W_valM;
      else if (wb.d_srcA != REG_NONE && wb.d_srcA == wb.W_dstE) wb.d_rvalA = wb.W_valE;
      if (wb.d_srcB != REG_NONE && wb.d_srcB == wb.W_dstM)      wb.d_rvalB = wb.W_valM;
      else if (wb.d_srcB != REG_NONE && wb.d_srcB == wb.W_dstE) wb.d_rvalB = wb.W_valE;
    end
`endif
  end

endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb -- directed self-checking bench for regfile_wb (CNT_W = 4 so
// the counter wrap is reachable in a few cycles).
module tb_regfile_wb;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [3:0]       cpu_stat;
  logic             halted;
  logic [CNT_W-1:0] retired_cnt;
  logic [1:0]       state_dbg;

  int n_total = 0;
  int n_bad   = 0;

  regfile_wb_if wb ();

  regfile_wb #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb          (wb),
    .cpu_stat    (cpu_stat),
    .halted      (halted),
    .retired_cnt (retired_cnt),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_w(input logic [3:0] stat, input logic [3:0] icode,
                         input logic [3:0] dste, input logic [63:0] vale,
                         input logic [3:0] dstm, input logic [63:0] valm);
    wb.W_stat  = stat;
    wb.W_icode = icode;
    wb.W_dstE  = dste;
    wb.W_valE  = vale;
    wb.W_dstM  = dstm;
    wb.W_valM  = valm;
  endtask

  task automatic drive_idle();
    drive_w(4'd1, 4'd1, 4'hF, 64'd0, 4'hF, 64'd0);
  endtask

  // Consume the current W entry, then return to a bubble.
  task automatic tick();
    @(posedge clk);
    #1;
    drive_idle();
    #1;
  endtask

  task automatic read_a(input logic [3:0] src, input logic [63:0] exp, input string tag);
    wb.d_srcA = src;
    #1;
    check(tag, wb.d_rvalA, exp);
  endtask

  task automatic read_b(input logic [3:0] src, input logic [63:0] exp, input string tag);
    wb.d_srcB = src;
    #1;
    check(tag, wb.d_rvalB, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic check_status(input logic [3:0] stat, input logic hlt,
                              input logic [CNT_W-1:0] cnt, input string tag);
    check({tag, "_stat"}, 64'(cpu_stat), 64'(stat));
    check({tag, "_halted"}, 64'(halted), 64'(hlt));
    check({tag, "_cnt"}, 64'(retired_cnt), 64'(cnt));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    wb.d_srcA = 4'hF;
    wb.d_srcB = 4'hF;
    drive_idle();
    @(posedge clk);
    #1;
    do_reset();

    // Reset state: every register reads 0, address F reads 0.
    for (int i = 0; i < 15; i++) read_a(4'(i), 64'd0, $sformatf("rst_reg%0d", i));
    read_a(4'hF, 64'd0, "rst_regF");
    check_status(4'd1, 1'b0, 4'd0, "rst");
    check("rst_state", 64'(state_dbg), 64'd0);

    // Single valE write, visible after the edge.
    wb.d_srcB = 4'd2;
    drive_w(4'd1, 4'd3, 4'd2, 64'h1234, 4'hF, 64'd0);
    #1;
`ifdef REGFILE_WB_BYPASS_EN
    check("byp_same_cycle", wb.d_rvalB, 64'h1234);
`else
    check("nobyp_same_cycle", wb.d_rvalB, 64'd0);
`endif
    tick();
    check("wr_e_reg2", wb.d_rvalB, 64'h1234);
    check_status(4'd1, 1'b0, 4'd1, "wr_e");

    // dstE == dstM: valM wins.
    drive_w(4'd1, 4'd11, 4'd4, 64'h10, 4'd4, 64'h20);
    tick();
    read_a(4'd4, 64'h20, "same_dst_reg4");
    check("same_dst_cnt", 64'(retired_cnt), 64'd2);

    // Two distinct destinations; both ports reading the same register.
    drive_w(4'd1, 4'd11, 4'd3, 64'hAA, 4'd5, 64'hBB);
    tick();
    read_a(4'd3, 64'hAA, "dual_reg3");
    read_a(4'd5, 64'hBB, "dual_reg5a");
    read_b(4'd5, 64'hBB, "dual_reg5b");

    // valM only, all ones into the top register.
    drive_w(4'd1, 4'd5, 4'hF, 64'h77, 4'd14, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    read_a(4'd14, 64'hFFFF_FFFF_FFFF_FFFF, "m_only_reg14");
    read_b(4'd2, 64'h1234, "m_only_reg2_kept");
    check("m_only_cnt", 64'(retired_cnt), 64'd4);

    // Bubbles are not counted.
    drive_idle();
    tick();
    tick();
    check("bubble_cnt", 64'(retired_cnt), 64'd4);

    // HLT: no write, status 2, counted.
    wb.d_srcA = 4'd1;
    drive_w(4'd2, 4'd0, 4'd1, 64'd5, 4'hF, 64'd0);
    #1;
    check("hlt_no_bypass", wb.d_rvalA, 64'd0);
    tick();
    read_a(4'd1, 64'd0, "hlt_reg1");
    check_status(4'd2, 1'b1, 4'd5, "hlt");
    check("hlt_state", 64'(state_dbg), 64'd1);

    // Frozen after HLT: AOK write and ADR are both ignored.
    drive_w(4'd1, 4'd3, 4'd1, 64'd7, 4'hF, 64'd0);
    tick();
    read_a(4'd1, 64'd0, "frozen_reg1");
    drive_w(4'd3, 4'd5, 4'hF, 64'd0, 4'd6, 64'd9);
    tick();
    check_status(4'd2, 1'b1, 4'd5, "frozen");
    read_a(4'd14, 64'hFFFF_FFFF_FFFF_FFFF, "frozen_read_reg14");

    // Reset wins over a simultaneous AOK write.
    drive_w(4'd1, 4'd3, 4'd1, 64'd7, 4'hF, 64'd0);
    do_reset();
    drive_idle();
    #1;
    read_a(4'd1, 64'd0, "rst2_reg1");
    read_a(4'd4, 64'd0, "rst2_reg4");
    check_status(4'd1, 1'b0, 4'd0, "rst2");

    // ADR: fault, not counted, no write.
    drive_w(4'd3, 4'd5, 4'hF, 64'd0, 4'd3, 64'h33);
    tick();
    read_a(4'd3, 64'd0, "adr_reg3");
    check_status(4'd3, 1'b1, 4'd0, "adr");
    check("adr_state", 64'(state_dbg), 64'd2);
    do_reset();
    check_status(4'd1, 1'b0, 4'd0, "rst3");

    // Undefined status codes map to INS.
    drive_w(4'd0, 4'd6, 4'd0, 64'd1, 4'hF, 64'd0);
    tick();
    check_status(4'd4, 1'b1, 4'd0, "stat0");
    do_reset();
    drive_w(4'd7, 4'd6, 4'd0, 64'd1, 4'hF, 64'd0);
    tick();
    check_status(4'd4, 1'b1, 4'd0, "stat7");
    do_reset();

    // Counter wrap: 16 counted entries plus 3 bubbles -> 0.
    for (int i = 0; i < 15; i++) begin
      drive_w(4'd1, 4'd6, 4'd0, 64'(i + 100), 4'hF, 64'd0);
      tick();
    end
    check("wrap_cnt15", 64'(retired_cnt), 64'd15);
    for (int i = 0; i < 3; i++) begin
      drive_w(4'd1, 4'd1, 4'hF, 64'd0, 4'hF, 64'd0);
      tick();
    end
    check("wrap_bubbles", 64'(retired_cnt), 64'd15);
    drive_w(4'd1, 4'd6, 4'd0, 64'h5A5A, 4'hF, 64'd0);
    tick();
    check("wrap_cnt0", 64'(retired_cnt), 64'd0);
    read_a(4'd0, 64'h5A5A, "wrap_reg0");
    check("wrap_stat", 64'(cpu_stat), 64'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
